// File: rtl/gatebach_host_ctrl.sv
// gatebach_host_ctrl: host-side sequencer for the sieve core's word-serial
// load/store interface. Pulls WORDS prime words from a valid/ready source,
// writes them into the core as addressed words, follows the core's
// load_done/proc_done/store_done flags, and AND-merges the core's result
// stream into an internal buffer exposed through a registered read port.
//
// Optional feature: define GATEBACH_HOST_TIMEOUT_EN to enable a per-phase
// watchdog (TIMEOUT_CYCLES) that aborts a stalled job to IDLE with err set.
//
// Ports:
//   clk, sys_rst_n                 clock, synchronous active-low reset
//   start                          one-cycle job request (ignored while busy)
//   prime_valid/prime_data/ready   upstream prime word source
//   cs_in/add_in/data_in           word writes into the core
//   load_done/proc_done/store_done core phase flags (level)
//   cs_out/add_out/data_out        core result-word stream
//   rd_addr/rd_data                result buffer read port (1-cycle latency)
//   busy/done/err                  job status
module gatebach_host_ctrl #(
    parameter int unsigned WORDS          = 100,
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              prime_valid,
    input  logic [DATA_W-1:0] prime_data,
    output logic              prime_ready,
    output logic              cs_in,
    output logic [ADDR_W-1:0] add_in,
    output logic [DATA_W-1:0] data_in,
    input  logic              load_done,
    input  logic              proc_done,
    input  logic              store_done,
    input  logic              cs_out,
    input  logic [ADDR_W-1:0] add_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_LOAD = 3'd2,
        S_WAIT_PROC = 3'd3,
        S_STORE     = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q [WORDS];
    logic [DATA_W-1:0] buf_d [WORDS];
    logic              prime_ready_q, prime_ready_d;
    logic              cs_in_q, cs_in_d;
    logic [ADDR_W-1:0] add_in_q, add_in_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef GATEBACH_HOST_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
    // The limit only feeds the watchdog build.
    logic unused_timeout_c;
    assign unused_timeout_c = ^32'(TIMEOUT_CYCLES);
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prime_ready_q <= 1'b0;
            cs_in_q       <= 1'b0;
            add_in_q      <= '0;
            data_in_q     <= '0;
            rd_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < int'(WORDS); i++) buf_q[i] <= '1;
`ifdef GATEBACH_HOST_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prime_ready_q <= prime_ready_d;
            cs_in_q       <= cs_in_d;
            add_in_q      <= add_in_d;
            data_in_q     <= data_in_d;
            rd_data_q     <= rd_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            for (int i = 0; i < int'(WORDS); i++) buf_q[i] <= buf_d[i];
`ifdef GATEBACH_HOST_TIMEOUT_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cs_in_d   = 1'b0;
        add_in_d  = add_in_q;
        data_in_d = data_in_q;
        err_d     = err_q;
        for (int i = 0; i < int'(WORDS); i++) buf_d[i] = buf_q[i];
        // Read port samples the pre-merge buffer contents.
        rd_data_d = (rd_addr <= LAST_ADDR) ? buf_q[rd_addr] : '0;
`ifdef GATEBACH_HOST_TIMEOUT_EN
        wdog_d    = '0;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    for (int i = 0; i < int'(WORDS); i++) buf_d[i] = '1;
                end
            end
            S_LOAD: begin
                if (prime_valid && prime_ready_q) begin
                    cs_in_d   = 1'b1;
                    add_in_d  = cnt_q;
                    data_in_d = prime_data;
                    cnt_d     = ADDR_W'(cnt_q + 1'b1);
                    if (cnt_q == LAST_ADDR) state_d = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: if (load_done) state_d = S_WAIT_PROC;
            S_WAIT_PROC: if (proc_done) state_d = S_STORE;
            S_STORE: begin
                if (cs_out) begin
                    if (add_out <= LAST_ADDR) buf_d[add_out] = buf_q[add_out] & data_out;
                    else                      err_d = 1'b1;
                end
                if (store_done) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef GATEBACH_HOST_TIMEOUT_EN
        // Watchdog only runs while parked in a wait phase; a flag wins a tie.
        if ((state_q == S_WAIT_LOAD || state_q == S_WAIT_PROC || state_q == S_STORE)
            && state_d == state_q) begin
            if (state_q == S_STORE && cs_out) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                wdog_d = WDOG_W'(wdog_q + 1'b1);
            end
        end
`endif

        prime_ready_d = (state_d == S_LOAD);
        busy_d        = (state_d == S_LOAD) || (state_d == S_WAIT_LOAD) ||
                        (state_d == S_WAIT_PROC) || (state_d == S_STORE);
        done_d        = (state_d == S_DONE);
    end

    assign prime_ready = prime_ready_q;
    assign cs_in       = cs_in_q;
    assign add_in      = add_in_q;
    assign data_in     = data_in_q;
    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/gatebach_host_ctrl.md
# gatebach_host_ctrl

Host-side sequencer for the sieve core's word-serial load/store interface. It pulls the prime list from an upstream valid/ready source and writes it into the core as addressed 32-bit words. It then follows the core's load_done / proc_done / store_done flags and collects the core's output stream into an internal result buffer, AND-merging each word. The buffer is readable by the system through a registered read port.

## Interface
- WORDS, 100, number of prime words loaded and result words collected
- ADDR_W, 7, word address width (WORDS ≤ 2**ADDR_W)
- DATA_W, 32, word width
- TIMEOUT_CYCLES, 65535, watchdog limit per wait phase (used only with GATEBACH_HOST_TIMEOUT_EN)

- clk  in  1  system clock; all logic on posedge
- sys_rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle job request; ignored while busy
- prime_valid  in  1  upstream prime word available
- prime_data  in  DATA_W  upstream prime word
- prime_ready  out  1  block accepts prime_data this cycle
- cs_in  out  1  word strobe to core
- add_in  out  ADDR_W  word address to core, 0..WORDS-1
- data_in  out  DATA_W  prime word to core
- load_done  in  1  core flag, level
- proc_done  in  1  core flag, level
- store_done  in  1  core flag, level
- cs_out  in  1  core result-word strobe
- add_out  in  ADDR_W  core result-word address
- data_out  in  DATA_W  core result word
- rd_addr  in  ADDR_W  result buffer read address
- rd_data  out  DATA_W  result word, registered
- busy  out  1  job in progress
- done  out  1  job complete; held until next accepted start
- err  out  1  sticky error; cleared by next accepted start

## Operation
- States: IDLE, LOAD, WAIT_LOAD, WAIT_PROC, STORE, DONE.
- IDLE/DONE + start: word counter ← 0, every buffer word ← all ones, done ← 0, err ← 0, next state LOAD.
- LOAD: prime_ready = 1. On prime_valid & prime_ready:
  - next cycle cs_in = 1, add_in = counter, data_in = prime_data;
  - counter increments.
  - After transfer WORDS-1, go to WAIT_LOAD.
  - cs_in = 0 on every cycle without a transfer.
- WAIT_LOAD: load_done = 1 → WAIT_PROC.
- WAIT_PROC: proc_done = 1 → STORE.
- STORE:
  - Each cycle with cs_out = 1 and add_out < WORDS: buf[add_out] ← buf[add_out] & data_out.
  - Repeated addresses accumulate by AND.
  - A cs_out with add_out ≥ WORDS is discarded and sets err; the job continues.
  - store_done = 1 → DONE. A cs_out in the same cycle as store_done is still merged.
- DONE: done = 1, busy = 0.
- busy = 1 in LOAD, WAIT_LOAD, WAIT_PROC and STORE.
- Flag or cs_out activity outside its own state is ignored.
- The read port is live in every state. During STORE it returns partially merged content.

## Timing
- Reset values:
  - state IDLE; prime_ready, cs_in, busy, done, err = 0;
  - add_in, data_in, rd_data = 0;
  - all buffer words all ones.
- Reset mid-job aborts immediately; no further cs_in pulses are issued.
- start at cycle T → LOAD and prime_ready = 1 from T+1.
- Latencies:
  - upstream transfer at cycle t → cs_in/add_in/data_in valid at t+1;
  - cs_out at cycle t → buffer updated at t+1;
  - rd_addr at cycle t → rd_data at t+1.
- Minimum LOAD with prime_valid held high: WORDS cycles. Last cs_in lands the cycle the state enters WAIT_LOAD.
- A flag seen at cycle t moves the state at t+1. Flags already high on entry advance in one cycle.
- Simultaneous rd_addr = add_out with cs_out: rd_data returns the pre-merge value.

## Configuration
- GATEBACH_HOST_TIMEOUT_EN defined:
  - a watchdog counter clears on entry to WAIT_LOAD, WAIT_PROC and STORE, and on each cs_out in STORE;
  - it increments on other cycles in those states;
  - on reaching TIMEOUT_CYCLES: err ← 1, state ← IDLE, done stays 0.
- Undefined: no counter, no timeout; wait states wait indefinitely and err arises only from out-of-range add_out.

## Test plan
- Reset, start, feed 3, 5, then 98 × 2 with prime_valid held → add_in 0..99 on consecutive cycles, data_in matching, busy = 1, cs_in drops after word 99.
- Stall prime_valid low for 5 cycles after word 10 → no cs_in during the gap; add_in resumes at 11 with no duplicate or skipped address.
- load_done, proc_done, then cs_out add 0 data 0xFFFF_FFFE, add 0 data 0x7FFF_FFFF, add 99 data 0x0 with store_done on the last → done = 1; rd_addr 0 gives 0x7FFF_FFFE; rd_addr 99 gives 0x0; rd_addr 50 gives 0xFFFF_FFFF.
- cs_out with add_out = 100 in STORE → err = 1, buffer unchanged, job still reaches DONE; the next start clears err and done.
- sys_rst_n low for 1 cycle mid-LOAD at word 40 → all outputs at reset values the next cycle; a fresh start restarts at add_in 0.
- With GATEBACH_HOST_TIMEOUT_EN and TIMEOUT_CYCLES = 16, load_done held 0 → err = 1, busy = 0, done = 0 exactly 16 cycles after entering WAIT_LOAD.
